// File: rtl/dense_layer_scheduler.sv
// rtl/dense_layer_scheduler.sv - sequences one time-shared MAC unit through a dense layer
// Per neuron: clear, stream NUM_INPUTS weight addresses, drain the ROM pipe, bias, activate, write.
module dense_layer_scheduler #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 16,
  parameter int ROM_LATENCY = 1,
  localparam int ADDR_W   = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  localparam int IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int NEURON_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inputs_ready,
  output logic [ADDR_W-1:0]   weight_address,
  output logic [IDX_W-1:0]    input_index,
  output logic [NEURON_W-1:0] neuron_index,
  output logic                mac_clear,
  output logic                mac_enable,
  output logic                bias_add,
  output logic                activate,
  output logic                output_write,
  output logic                busy,
  output logic                outputs_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEARING, S_ACCUMULATING, S_DRAINING,
    S_BIASING, S_ACTIVATING, S_WRITING, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]    ISSUE_LAST  = IDX_W'(NUM_INPUTS - 1);
  localparam logic [NEURON_W-1:0] NEURON_LAST = NEURON_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0]   ADDR_STRIDE = ADDR_W'(NUM_INPUTS);
  localparam logic [2:0]          DRAIN_LAST  = 3'((ROM_LATENCY > 0) ? ROM_LATENCY - 1 : 0);

  state_t                state, state_next;
  logic [IDX_W-1:0]      issue_index;
  logic [NEURON_W-1:0]   neuron_count;
  logic [ADDR_W-1:0]     addr_base;
  logic [2:0]            drain_count;
  logic                  issue_last, drain_last, neuron_last, busy_state;

  assign issue_last  = (issue_index == ISSUE_LAST);
  assign drain_last  = (drain_count == DRAIN_LAST);
  assign neuron_last = (neuron_count == NEURON_LAST);
  assign busy_state  = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:         if (inputs_ready) state_next = S_CLEARING;
      S_CLEARING:     state_next = S_ACCUMULATING;
      S_ACCUMULATING: if (issue_last) state_next = (ROM_LATENCY == 0) ? S_BIASING : S_DRAINING;
      S_DRAINING:     if (drain_last) state_next = S_BIASING;
      S_BIASING:      state_next = S_ACTIVATING;
      S_ACTIVATING:   state_next = S_WRITING;
      S_WRITING:      state_next = neuron_last ? S_DONE : S_CLEARING;
      S_DONE:         if (!inputs_ready) state_next = S_IDLE;
      default:        state_next = S_IDLE;
    endcase
    // Losing inputs_ready mid-layer abandons the layer from any working state.
    if (busy_state && !inputs_ready) state_next = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_index  <= '0;
      neuron_count <= '0;
      addr_base    <= '0;
      drain_count  <= '0;
    end else if (state_next == S_IDLE) begin
      issue_index  <= '0;
      neuron_count <= '0;
      addr_base    <= '0;
      drain_count  <= '0;
    end else begin
      case (state)
        S_ACCUMULATING: begin
          if (!issue_last) issue_index <= issue_index + IDX_W'(1);
          drain_count <= '0;
        end
        S_DRAINING: if (!drain_last) drain_count <= drain_count + 3'd1;
        S_WRITING: begin
          issue_index <= '0;
          if (!neuron_last) begin
            neuron_count <= neuron_count + NEURON_W'(1);
            addr_base    <= addr_base + ADDR_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // The MAC sees each weight ROM_LATENCY cycles after its address, so delay the enable and index to match.
  if (ROM_LATENCY == 0) begin : g_no_pipe
    assign mac_enable  = (state == S_ACCUMULATING);
    assign input_index = issue_index;
  end else begin : g_pipe
    logic [ROM_LATENCY-1:0] pipe_valid;
    logic [IDX_W-1:0]       pipe_index [ROM_LATENCY];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pipe_valid <= '0;
        for (int i = 0; i < ROM_LATENCY; i++) pipe_index[i] <= '0;
      end else if (state_next == S_IDLE) begin
        pipe_valid <= '0;
        for (int i = 0; i < ROM_LATENCY; i++) pipe_index[i] <= '0;
      end else begin
        pipe_valid[0] <= (state == S_ACCUMULATING);
        pipe_index[0] <= issue_index;
        for (int i = 1; i < ROM_LATENCY; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_index[i] <= pipe_index[i-1];
        end
      end
    end

    assign mac_enable  = pipe_valid[ROM_LATENCY-1];
    assign input_index = pipe_index[ROM_LATENCY-1];
  end

  assign weight_address = addr_base + ADDR_W'(issue_index);
  assign neuron_index   = neuron_count;
  assign mac_clear      = (state == S_CLEARING);
  assign bias_add       = (state == S_BIASING);
  assign activate       = (state == S_ACTIVATING);
  assign output_write   = (state == S_WRITING);
  assign busy           = busy_state;
  assign outputs_ready  = (state == S_DONE);

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// tb/tb_dense_layer_scheduler.sv - bench for dense_layer_scheduler
// Two instances: A (4 inputs, 3 neurons, latency 1) and B (1 input, 1 neuron, latency 0).
module tb_dense_layer_scheduler;

  localparam int WA_A = 4, WI_A = 2, WN_A = 2;
  localparam int WA_B = 1, WI_B = 1, WN_B = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ir_a = 1'b0, ir_b = 1'b0;

  logic [WA_A-1:0] weight_address_a;
  logic [WI_A-1:0] input_index_a;
  logic [WN_A-1:0] neuron_index_a;
  logic mac_clear_a, mac_enable_a, bias_add_a, activate_a, output_write_a, busy_a, outputs_ready_a;

  logic [WA_B-1:0] weight_address_b;
  logic [WI_B-1:0] input_index_b;
  logic [WN_B-1:0] neuron_index_b;
  logic mac_clear_b, mac_enable_b, bias_add_b, activate_b, output_write_b, busy_b, outputs_ready_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dense_layer_scheduler #(.NUM_INPUTS(4), .NUM_NEURONS(3), .ROM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .inputs_ready(ir_a),
    .weight_address(weight_address_a), .input_index(input_index_a), .neuron_index(neuron_index_a),
    .mac_clear(mac_clear_a), .mac_enable(mac_enable_a), .bias_add(bias_add_a), .activate(activate_a),
    .output_write(output_write_a), .busy(busy_a), .outputs_ready(outputs_ready_a)
  );

  dense_layer_scheduler #(.NUM_INPUTS(1), .NUM_NEURONS(1), .ROM_LATENCY(0)) dut_b (
    .clock(clock), .reset(reset), .inputs_ready(ir_b),
    .weight_address(weight_address_b), .input_index(input_index_b), .neuron_index(neuron_index_b),
    .mac_clear(mac_clear_b), .mac_enable(mac_enable_b), .bias_add(bias_add_b), .activate(activate_b),
    .output_write(output_write_b), .busy(busy_b), .outputs_ready(outputs_ready_b)
  );

  // Strobe vector order: busy, outputs_ready, mac_clear, mac_enable, bias_add, activate, output_write.
  logic [6:0] obs_a, obs_b;
  assign obs_a = {busy_a, outputs_ready_a, mac_clear_a, mac_enable_a, bias_add_a, activate_a, output_write_a};
  assign obs_b = {busy_b, outputs_ready_b, mac_clear_b, mac_enable_b, bias_add_b, activate_b, output_write_b};

  typedef struct {
    logic [6:0] strobes;
    bit         acc;
    int         addr;
    int         idx;
    int         nidx;
  } exp_t;

  // Expected outputs t cycles after the edge that started the layer, from the per-neuron schedule.
  function automatic exp_t model(input int n, input int l, input int nn, input int t);
    exp_t e;
    int p, ph;
    p = n + l + 4;
    e.strobes = 7'b0;
    e.acc = 1'b0;
    e.addr = 0;
    e.idx = 0;
    e.nidx = nn - 1;
    if (t >= nn * p) begin
      e.strobes = 7'b0100000;
      return e;
    end
    e.nidx = t / p;
    ph = t % p;
    e.acc = (ph >= 1) && (ph <= n);
    e.addr = e.nidx * n + ph - 1;
    e.idx = ph - 1 - l;
    e.strobes = {1'b1, 1'b0, ph == 0, (ph >= l + 1) && (ph <= l + n), ph == n + l + 1,
                 ph == n + l + 2, ph == n + l + 3};
    return e;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (obs_a !== 7'b0 || weight_address_a !== '0 || input_index_a !== '0 || neuron_index_a !== '0) begin
      failures++;
      $display("FAIL reset_a: strobes=%b addr=%0d idx=%0d nidx=%0d, required all 0",
               obs_a, weight_address_a, input_index_a, neuron_index_a);
    end
    checks++;
    if (obs_b !== 7'b0 || weight_address_b !== '0 || input_index_b !== '0 || neuron_index_b !== '0) begin
      failures++;
      $display("FAIL reset_b: strobes=%b addr=%0d idx=%0d nidx=%0d, required all 0",
               obs_b, weight_address_b, input_index_b, neuron_index_b);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      checks++;
      if (obs_a !== 7'b0) begin
        failures++;
        $display("FAIL idle_hold_a: strobes=%b, required 0000000", obs_a);
      end
    end
  endtask

  task automatic test_full_run(input string name, input int hold);
    exp_t e;
    int wq[$];
    int first_ready;
    first_ready = 0;
    ir_a = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clock); #1;
      e = model(4, 1, 3, k - 1);
      checks++;
      if (obs_a !== e.strobes) begin
        failures++;
        $display("FAIL %s strobes edge %0d: got %b required %b", name, k, obs_a, e.strobes);
      end
      checks++;
      if (neuron_index_a !== WN_A'(e.nidx)) begin
        failures++;
        $display("FAIL %s neuron_index edge %0d: got %0d required %0d", name, k, neuron_index_a, e.nidx);
      end
      if (e.acc) begin
        checks++;
        if (weight_address_a !== WA_A'(e.addr)) begin
          failures++;
          $display("FAIL %s weight_address edge %0d: got %0d required %0d", name, k, weight_address_a, e.addr);
        end
      end
      if (e.strobes[3]) begin
        checks++;
        if (input_index_a !== WI_A'(e.idx)) begin
          failures++;
          $display("FAIL %s input_index edge %0d: got %0d required %0d", name, k, input_index_a, e.idx);
        end
      end
      if (output_write_a === 1'b1) wq.push_back(int'(neuron_index_a));
      if (outputs_ready_a === 1'b1 && first_ready == 0) first_ready = k;
    end
    checks++;
    if (first_ready != 28) begin
      failures++;
      $display("FAIL %s ready_edge: got %0d required 28", name, first_ready);
    end
    checks++;
    if (wq.size() != 3) begin
      failures++;
      $display("FAIL %s write_count: got %0d required 3", name, wq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] != i) begin
        failures++;
        $display("FAIL %s write_slot %0d: got %0d required %0d", name, i, (i < wq.size()) ? wq[i] : -1, i);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      checks++;
      if (obs_a !== 7'b0100000) begin
        failures++;
        $display("FAIL %s done_hold %0d: got %b required 0100000", name, h, obs_a);
      end
    end
    ir_a = 1'b0;
    checks++;
    if (outputs_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_release_edge: got %b required 1", name, outputs_ready_a);
    end
    @(posedge clock); #1;
    checks++;
    if (obs_a !== 7'b0) begin
      failures++;
      $display("FAIL %s release_idle: got %b required 0000000", name, obs_a);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int first_ready;
    first_ready = 0;
    ir_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      e = model(1, 0, 1, k - 1);
      checks++;
      if (obs_b !== e.strobes) begin
        failures++;
        $display("FAIL single strobes edge %0d: got %b required %b", k, obs_b, e.strobes);
      end
      if (e.acc) begin
        checks++;
        if (weight_address_b !== WA_B'(e.addr) || input_index_b !== WI_B'(e.idx)) begin
          failures++;
          $display("FAIL single addr/idx edge %0d: got %0d/%0d required %0d/%0d",
                   k, weight_address_b, input_index_b, e.addr, e.idx);
        end
      end
      if (outputs_ready_b === 1'b1 && first_ready == 0) first_ready = k;
    end
    checks++;
    if (first_ready != 6) begin
      failures++;
      $display("FAIL single ready_edge: got %0d required 6", first_ready);
    end
    ir_b = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (obs_b !== 7'b0) begin
      failures++;
      $display("FAIL single release_idle: got %b required 0000000", obs_b);
    end
  endtask

  task automatic test_abort(input int drop_t);
    exp_t e;
    ir_a = 1'b1;
    for (int k = 1; k <= drop_t + 1; k++) begin
      @(posedge clock); #1;
      e = model(4, 1, 3, k - 1);
      checks++;
      if (obs_a !== e.strobes) begin
        failures++;
        $display("FAIL abort(t=%0d) pre strobes edge %0d: got %b required %b", drop_t, k, obs_a, e.strobes);
      end
    end
    ir_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      checks++;
      if (obs_a !== 7'b0) begin
        failures++;
        $display("FAIL abort(t=%0d) idle cycle %0d: got %b required 0000000", drop_t, k, obs_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int drop_t;
    drop_t = 18 + int'($urandom_range(1, 4));
    ir_a = 1'b1;
    for (int k = 1; k <= drop_t + 1; k++) begin
      @(posedge clock); #1;
      e = model(4, 1, 3, k - 1);
      checks++;
      if (obs_a !== e.strobes) begin
        failures++;
        $display("FAIL reset_mid pre strobes edge %0d: got %b required %b", k, obs_a, e.strobes);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_a !== 7'b0 || weight_address_a !== '0 || input_index_a !== '0 || neuron_index_a !== '0) begin
      failures++;
      $display("FAIL reset_mid async: strobes=%b addr=%0d idx=%0d nidx=%0d, required all 0",
               obs_a, weight_address_a, input_index_a, neuron_index_a);
    end
    ir_a = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (obs_a !== 7'b0 || neuron_index_a !== '0) begin
      failures++;
      $display("FAIL reset_mid held: strobes=%b nidx=%0d, required 0", obs_a, neuron_index_a);
    end
    @(negedge clock);
    reset = 1'b0;
    test_full_run("after_reset", 5);
  endtask

  task automatic test_back_to_back();
    test_full_run("b2b_first", int'($urandom_range(1, 8)));
    test_full_run("b2b_second", int'($urandom_range(1, 8)));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    test_reset();
    test_full_run("full_run", 5);
    test_single();
    test_abort(9 + int'($urandom_range(1, 4)));
    test_full_run("restart", 5);
    repeat (3) test_abort(int'($urandom_range(0, 26)));
    test_full_run("done_hold", int'($urandom_range(1, 10)));
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
